// File: rtl/note_dropper_if.sv
// Keyboard-in / sprite-out bundle between the game top level and one falling-note lane.
interface note_dropper_if;
    logic [7:0] keycode;
    logic [7:0] keycode_second;
    logic [9:0] dropX;
    logic [9:0] dropY;
    logic       visible;
    logic       score_pulse;
    logic       hit;
    logic       miss;

    modport master (
        output keycode, keycode_second,
        input  dropX, dropY, visible, score_pulse, hit, miss
    );

    modport slave (
        input  keycode, keycode_second,
        output dropX, dropY, visible, score_pulse, hit, miss
    );
endinterface

// File: rtl/note_dropper.sv
// One rhythm-game lane: a note waits DELAY frames after start, falls SPEED px/frame,
// and is scored as a hit on a fresh key press inside the window or a miss at the bottom.
module note_dropper #(
    parameter int         X_START     = 220,
    parameter int         Y_START     = 100,
    parameter int         Y_MAX       = 400,
    parameter int         SIZE        = 40,
    parameter int         DELAY       = 1380,
    parameter int         SPEED       = 1,
    parameter logic [7:0] KEYCODE     = 8'h51,
    parameter int         HIT_LO      = 340,
    parameter int         HIT_HI      = 400,
    parameter logic [7:0] START_KEY   = 8'h2c,
    parameter logic [7:0] RESTART_KEY = 8'h01
) (
    input logic          frame_clk,
    input logic          Reset_n,
    note_dropper_if.slave bus
);

    localparam logic [9:0]  Y_START_V  = 10'(Y_START);
    localparam logic [10:0] Y_MAX_V    = 11'(Y_MAX);
    localparam logic [10:0] SIZE_V     = 11'(SIZE);
    localparam logic [10:0] SPEED_V    = 11'(SPEED);
    localparam logic [10:0] HIT_LO_V   = 11'(HIT_LO);
    localparam logic [10:0] HIT_HI_V   = 11'(HIT_HI);
    localparam logic [10:0] Y_LIMIT    = 11'(Y_MAX - SIZE);
    localparam logic [11:0] LAST_COUNT = 12'(DELAY - 1);

    typedef enum logic [2:0] {IDLE, WAIT, FALL, HIT, MISS} state_t;

    state_t      state, state_next;
    logic [11:0] counter, counter_next;
    logic [9:0]  drop_y, drop_y_next;
    logic        key_prev, key_now, press;
    logic        hit_flag, hit_next;
    logic        miss_flag, miss_next;
    logic        pulse, pulse_next;
    logic [10:0] bottom, advanced;

    assign key_now  = (bus.keycode == KEYCODE) || (bus.keycode_second == KEYCODE);
    assign press    = key_now && !key_prev;
    assign bottom   = {1'b0, drop_y} + SIZE_V;
    assign advanced = {1'b0, drop_y} + SPEED_V;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            counter   <= '0;
            drop_y    <= Y_START_V;
            key_prev  <= 1'b0;
            hit_flag  <= 1'b0;
            miss_flag <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            state     <= state_next;
            counter   <= counter_next;
            drop_y    <= drop_y_next;
            key_prev  <= key_now;
            hit_flag  <= hit_next;
            miss_flag <= miss_next;
            pulse     <= pulse_next;
        end
    end

    // Miss is tested before hit so a press on the frame the note bottoms out still misses.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        drop_y_next  = drop_y;
        hit_next     = hit_flag;
        miss_next    = miss_flag;
        pulse_next   = 1'b0;
        case (state)
            IDLE: begin
                drop_y_next  = Y_START_V;
                counter_next = '0;
                if (bus.keycode == START_KEY)
                    state_next = (DELAY == 0) ? FALL : WAIT;
            end
            WAIT: begin
                counter_next = counter + 12'd1;
                if (counter == LAST_COUNT)
                    state_next = FALL;
            end
            FALL: begin
                if (bottom >= Y_MAX_V) begin
                    state_next = MISS;
                    miss_next  = 1'b1;
                end else if (press && bottom >= HIT_LO_V && bottom < HIT_HI_V) begin
                    state_next = HIT;
                    hit_next   = 1'b1;
                    pulse_next = 1'b1;
                end else begin
                    drop_y_next = (advanced > Y_LIMIT) ? Y_LIMIT[9:0] : advanced[9:0];
                end
            end
            HIT, MISS: begin
                if (bus.keycode == RESTART_KEY) begin
                    state_next   = IDLE;
                    hit_next     = 1'b0;
                    miss_next    = 1'b0;
                    drop_y_next  = Y_START_V;
                    counter_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.dropX       = 10'(X_START);
    assign bus.dropY       = drop_y;
    assign bus.visible     = (state != HIT) && (state != MISS);
    assign bus.score_pulse = pulse;
    assign bus.hit         = hit_flag;
    assign bus.miss        = miss_flag;

endmodule

// File: tb/tb_note_dropper.sv
// Bench for note_dropper: a default-parameter lane and a fast lane (SPEED=7, DELAY=0).
module tb_note_dropper;

    localparam logic [7:0] START   = 8'h2c;
    localparam logic [7:0] RESTART = 8'h01;
    localparam logic [7:0] LANE    = 8'h51;

    typedef struct packed {
        logic [9:0] y;
        logic       vis;
        logic       hit;
        logic       miss;
        logic       pulse;
    } exp_t;

    typedef struct {
        logic [7:0] k1;
        logic [7:0] k2;
        exp_t       e;
    } vec_t;

    logic frame_clk = 1'b0;
    logic Reset_n;
    exp_t sb[$];
    int   checks;
    int   errors;

    always #5 frame_clk = ~frame_clk;

    note_dropper_if def_if();
    note_dropper_if fast_if();

    note_dropper u_def (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (def_if)
    );

    note_dropper #(.DELAY(0), .SPEED(7)) u_fast (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (fast_if)
    );

    function automatic exp_t mk(input int y, input bit vis, input bit h, input bit m, input bit p);
        exp_t e;
        e.y     = 10'(y);
        e.vis   = vis;
        e.hit   = h;
        e.miss  = m;
        e.pulse = p;
        return e;
    endfunction

    task automatic checkOutput(input bit fast, input string name);
        exp_t       e;
        exp_t       a;
        logic [9:0] x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (fast) begin
            a = {fast_if.dropY, fast_if.visible, fast_if.hit, fast_if.miss, fast_if.score_pulse};
            x = fast_if.dropX;
        end else begin
            a = {def_if.dropY, def_if.visible, def_if.hit, def_if.miss, def_if.score_pulse};
            x = def_if.dropX;
        end
        if (a !== e || x !== 10'd220) begin
            errors++;
            $display("[TB] FAIL %s: got y=%0d vis=%b hit=%b miss=%b pulse=%b x=%0d, want y=%0d vis=%b hit=%b miss=%b pulse=%b x=220",
                     name, a.y, a.vis, a.hit, a.miss, a.pulse, x, e.y, e.vis, e.hit, e.miss, e.pulse);
        end
    endtask

    task automatic applyStimulus(input bit fast, input logic [7:0] k1, input logic [7:0] k2,
                                 input exp_t e, input string name);
        sb.push_back(e);
        if (fast) begin
            fast_if.keycode        = k1;
            fast_if.keycode_second = k2;
        end else begin
            def_if.keycode         = k1;
            def_if.keycode_second  = k2;
        end
        @(posedge frame_clk);
        #1;
        checkOutput(fast, name);
    endtask

    task automatic do_reset();
        def_if.keycode         = 8'h00;
        def_if.keycode_second  = 8'h00;
        fast_if.keycode        = 8'h00;
        fast_if.keycode_second = 8'h00;
        Reset_n = 1'b0;
        #2;
        sb.push_back(mk(100, 1, 0, 0, 0));
        checkOutput(0, "reset_def");
        sb.push_back(mk(100, 1, 0, 0, 0));
        checkOutput(1, "reset_fast");
        Reset_n = 1'b1;
    endtask

    task automatic start_and_wait();
        applyStimulus(0, START, 8'h00, mk(100, 1, 0, 0, 0), "start");
        for (int i = 1; i <= 1380; i++)
            applyStimulus(0, 8'h00, 8'h00, mk(100, 1, 0, 0, 0), "delay_hold");
    endtask

    task automatic fall_default(input int first, input int last, input logic [7:0] k1);
        for (int n = first; n <= last; n++)
            applyStimulus(0, k1, 8'h00, mk(100 + n, 1, 0, 0, 0), "fall");
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   y;

        checks  = 0;
        errors  = 0;
        Reset_n = 1'b1;
        #1;

        // Default lane, no key: full delay, fall, miss at 360, restart.
        do_reset();
        start_and_wait();
        fall_default(1, 260, 8'h00);
        applyStimulus(0, 8'h00, 8'h00, mk(360, 0, 0, 1, 0), "miss_at_360");
        applyStimulus(0, START, 8'h00, mk(360, 0, 0, 1, 0), "start_ignored_in_miss");
        applyStimulus(0, 8'h00, 8'h00, mk(360, 0, 0, 1, 0), "miss_hold");
        applyStimulus(0, RESTART, 8'h00, mk(100, 1, 0, 0, 0), "restart_to_idle");
        applyStimulus(0, 8'h00, 8'h00, mk(100, 1, 0, 0, 0), "idle_no_autostart");

        // Fresh press on keycode_second at 305 scores once.
        do_reset();
        start_and_wait();
        fall_default(1, 205, 8'h00);
        applyStimulus(0, 8'h00, LANE, mk(305, 0, 1, 0, 1), "hit_305");
        applyStimulus(0, 8'h00, LANE, mk(305, 0, 1, 0, 0), "pulse_one_frame");
        applyStimulus(0, 8'h00, 8'h00, mk(305, 0, 1, 0, 0), "hit_sticky");
        applyStimulus(0, RESTART, 8'h00, mk(100, 1, 0, 0, 0), "restart_after_hit");

        // Key held from 290 never produces a fresh press inside the window.
        do_reset();
        start_and_wait();
        fall_default(1, 190, 8'h00);
        fall_default(191, 260, LANE);
        applyStimulus(0, LANE, 8'h00, mk(360, 0, 0, 1, 0), "held_key_miss");

        // Press at bottom 338 is too early; fresh press at bottom 340 hits.
        do_reset();
        start_and_wait();
        fall_default(1, 198, 8'h00);
        applyStimulus(0, LANE, 8'h00, mk(299, 1, 0, 0, 0), "press_below_window");
        applyStimulus(0, 8'h00, 8'h00, mk(300, 1, 0, 0, 0), "release");
        applyStimulus(0, LANE, 8'h00, mk(300, 0, 1, 0, 1), "hit_at_window_low");

        // Asynchronous reset mid-fall, then restart key in IDLE is inert.
        do_reset();
        start_and_wait();
        fall_default(1, 150, 8'h00);
        Reset_n = 1'b0;
        #2;
        sb.push_back(mk(100, 1, 0, 0, 0));
        checkOutput(0, "async_reset_midfall");
        Reset_n = 1'b1;
        applyStimulus(0, RESTART, 8'h00, mk(100, 1, 0, 0, 0), "restart_in_idle");
        applyStimulus(0, 8'h00, 8'h00, mk(100, 1, 0, 0, 0), "idle_hold");
        start_and_wait();
        applyStimulus(0, 8'h00, 8'h00, mk(101, 1, 0, 0, 0), "full_delay_again");

        // Fast lane: table for the opening frames, then clamp and miss priority.
        do_reset();
        vecs[0] = '{START,   8'h00, mk(100, 1, 0, 0, 0)};
        vecs[1] = '{8'h00,   8'h00, mk(107, 1, 0, 0, 0)};
        vecs[2] = '{START,   8'h00, mk(114, 1, 0, 0, 0)};
        vecs[3] = '{RESTART, 8'h00, mk(121, 1, 0, 0, 0)};
        vecs[4] = '{8'h00,   LANE,  mk(128, 1, 0, 0, 0)};
        vecs[5] = '{8'h00,   8'h00, mk(135, 1, 0, 0, 0)};
        for (int i = 0; i < 6; i++)
            applyStimulus(1, vecs[i].k1, vecs[i].k2, vecs[i].e, $sformatf("fast_vec%0d", i));
        y = 135;
        for (int i = 0; i < 40 && y < 360; i++) begin
            y = (y + 7 > 360) ? 360 : y + 7;
            applyStimulus(1, 8'h00, 8'h00, mk(y, 1, 0, 0, 0), "fast_fall_clamp");
        end
        applyStimulus(1, LANE, 8'h00, mk(360, 0, 0, 1, 0), "miss_beats_press");

        // Fast lane: fresh press at bottom 399 is the last hittable frame.
        do_reset();
        applyStimulus(1, START, 8'h00, mk(100, 1, 0, 0, 0), "fast_start");
        y = 100;
        for (int i = 0; i < 40 && y < 359; i++) begin
            y = y + 7;
            applyStimulus(1, 8'h00, 8'h00, mk(y, 1, 0, 0, 0), "fast_fall");
        end
        applyStimulus(1, 8'h00, LANE, mk(359, 0, 1, 0, 1), "hit_at_window_high");
        applyStimulus(1, 8'h00, 8'h00, mk(359, 0, 1, 0, 0), "fast_pulse_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
